// File: rtl/comparador_4b_reg.sv
// Registered magnitude comparator stage: one-hot G/L/E flags, max/min/|A-B|,
// and saturating per-outcome event counters. One cycle latency, full throughput.
module comparador_4b_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic             cnt_clr,
  output logic             G,
  output logic             L,
  output logic             E,
  output logic             out_valid,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] abs_diff,
  output logic [CNT_W-1:0] cnt_g,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_e
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic [WIDTH-1:0] max_next;
  logic [WIDTH-1:0] min_next;
  logic [WIDTH-1:0] diff_next;
  logic [2:0]       hit;

  logic             g_reg;
  logic             l_reg;
  logic             e_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] max_reg;
  logic [WIDTH-1:0] min_reg;
  logic [WIDTH-1:0] diff_reg;

  always_comb begin
    a_eq_b = (a == b);
    if (signed_mode) begin
      a_gt_b = ($signed(a) > $signed(b));
    end else begin
      a_gt_b = (a > b);
    end
    a_lt_b   = ~a_gt_b & ~a_eq_b;
    max_next = a_lt_b ? b : a;
    min_next = a_lt_b ? a : b;
    // max - min is non-negative and below 2^WIDTH in both modes, so the
    // WIDTH-bit modular difference equals the truncated WIDTH+1-bit one.
    diff_next = max_next - min_next;
    hit       = {a_eq_b, a_lt_b, a_gt_b};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      g_reg         <= 1'b0;
      l_reg         <= 1'b0;
      e_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
      max_reg       <= '0;
      min_reg       <= '0;
      diff_reg      <= '0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        g_reg    <= a_gt_b;
        l_reg    <= a_lt_b;
        e_reg    <= a_eq_b;
        max_reg  <= max_next;
        min_reg  <= min_next;
        diff_reg <= diff_next;
      end
    end
  end

  // Counter index 0 = greater, 1 = less, 2 = equal; clear beats a same-cycle hit.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rstn || cnt_clr) begin
        cnt_reg <= '0;
      end else if (in_valid && hit[gi] && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

  assign G         = g_reg;
  assign L         = l_reg;
  assign E         = e_reg;
  assign out_valid = out_valid_reg;
  assign max_out   = max_reg;
  assign min_out   = min_reg;
  assign abs_diff  = diff_reg;
  assign cnt_g     = g_cnt[0].cnt_reg;
  assign cnt_l     = g_cnt[1].cnt_reg;
  assign cnt_e     = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_comparador_4b_reg.sv
// Self-checking bench: directed scenarios plus random traffic against an
// integer-arithmetic reference model; two instances (8-bit and 2-bit counters).
module tb_comparador_4b_reg;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [TW-1:0] a, b;
  logic          in_valid, signed_mode, cnt_clr;

  logic          g0, l0, e0, ov0, g1, l1, e1, ov1;
  logic [TW-1:0] mx0, mn0, ad0, mx1, mn1, ad1;
  logic [7:0]    cg0, cl0, ce0;
  logic [1:0]    cg1, cl1, ce1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int exp_g, exp_l, exp_e, exp_ov, exp_max, exp_min, exp_abs;
  int exp_cnt8 [3];
  int exp_cnt2 [3];

  always #5 clk = ~clk;

  comparador_4b_reg #(.WIDTH(TW), .CNT_W(8)) dut_big (
    .clk(clk), .rstn(rstn), .a(a), .b(b), .in_valid(in_valid),
    .signed_mode(signed_mode), .cnt_clr(cnt_clr),
    .G(g0), .L(l0), .E(e0), .out_valid(ov0),
    .max_out(mx0), .min_out(mn0), .abs_diff(ad0),
    .cnt_g(cg0), .cnt_l(cl0), .cnt_e(ce0)
  );

  comparador_4b_reg #(.WIDTH(TW), .CNT_W(2)) dut_small (
    .clk(clk), .rstn(rstn), .a(a), .b(b), .in_valid(in_valid),
    .signed_mode(signed_mode), .cnt_clr(cnt_clr),
    .G(g1), .L(l1), .E(e1), .out_valid(ov1),
    .max_out(mx1), .min_out(mn1), .abs_diff(ad1),
    .cnt_g(cg1), .cnt_l(cl1), .cnt_e(ce1)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int as_value(input logic [TW-1:0] v, input logic sm);
    int x;
    x = int'(v);
    if (sm && x >= (1 << (TW - 1))) x = x - (1 << TW);
    return x;
  endfunction

  always @(posedge clk) begin
    int va, vb, idx;
    if (!rstn) begin
      exp_g = 0; exp_l = 0; exp_e = 0; exp_ov = 0;
      exp_max = 0; exp_min = 0; exp_abs = 0;
      for (int i = 0; i < 3; i++) begin
        exp_cnt8[i] = 0;
        exp_cnt2[i] = 0;
      end
    end else begin
      exp_ov = in_valid ? 1 : 0;
      idx = 0;
      if (in_valid) begin
        va = as_value(a, signed_mode);
        vb = as_value(b, signed_mode);
        exp_g = (va > vb) ? 1 : 0;
        exp_l = (va < vb) ? 1 : 0;
        exp_e = (va == vb) ? 1 : 0;
        exp_max = (va < vb) ? int'(b) : int'(a);
        exp_min = (va < vb) ? int'(a) : int'(b);
        exp_abs = (va > vb) ? (va - vb) : (vb - va);
        idx = exp_g ? 0 : (exp_l ? 1 : 2);
      end
      if (cnt_clr) begin
        for (int i = 0; i < 3; i++) begin
          exp_cnt8[i] = 0;
          exp_cnt2[i] = 0;
        end
      end else if (in_valid) begin
        if (exp_cnt8[idx] < 255) exp_cnt8[idx]++;
        if (exp_cnt2[idx] < 3) exp_cnt2[idx]++;
      end
    end
  end

  always @(negedge clk) begin
    check("G", g0, exp_g);          check("L", l0, exp_l);
    check("E", e0, exp_e);          check("out_valid", ov0, exp_ov);
    check("max_out", mx0, exp_max); check("min_out", mn0, exp_min);
    check("abs_diff", ad0, exp_abs);
    check("cnt_g", cg0, exp_cnt8[0]);
    check("cnt_l", cl0, exp_cnt8[1]);
    check("cnt_e", ce0, exp_cnt8[2]);
    check("small_G", g1, exp_g);    check("small_L", l1, exp_l);
    check("small_E", e1, exp_e);    check("small_out_valid", ov1, exp_ov);
    check("small_max", mx1, exp_max);
    check("small_abs", ad1, exp_abs);
    check("small_cnt_g", cg1, exp_cnt2[0]);
    check("small_cnt_l", cl1, exp_cnt2[1]);
    check("small_cnt_e", ce1, exp_cnt2[2]);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_op(input int av, input int bv, input logic sm);
    a = TW'(av); b = TW'(bv); signed_mode = sm; in_valid = 1'b1;
    cycle();
    $display("op a=%0d b=%0d signed=%0d -> G=%0d L=%0d E=%0d max=%0d min=%0d abs=%0d",
             av, bv, sm, g0, l0, e0, mx0, mn0, ad0);
  endtask

  initial begin
    rstn = 1'b0; cnt_clr = 1'b0; in_valid = 1'b1; signed_mode = 1'b1;
    a = 4'd9; b = 4'd3;
    #1;
    cycle(); cycle();
    check("rst_out_valid", ov0, 0); check("rst_G", g0, 0);
    check("rst_max", mx0, 0);       check("rst_cnt_l", cl0, 0);
    rstn = 1'b1; in_valid = 1'b0;
    cycle();
    check("post_rst_out_valid", ov0, 0); check("post_rst_E", e0, 0);
    $display("reset released");

    compare_op(4, 4, 1'b0);
    check("seq_eq_E", e0, 1); check("seq_eq_max", mx0, 4);
    check("seq_eq_min", mn0, 4); check("seq_eq_abs", ad0, 0);
    compare_op(4, 1, 1'b0);
    check("seq_gt_G", g0, 1); check("seq_gt_min", mn0, 1); check("seq_gt_abs", ad0, 3);
    compare_op(4, 14, 1'b0);
    check("seq_lt_L", l0, 1); check("seq_lt_max", mx0, 14); check("seq_lt_abs", ad0, 10);
    check("seq_cnt_e", ce0, 1); check("seq_cnt_g", cg0, 1); check("seq_cnt_l", cl0, 1);

    compare_op(4, 14, 1'b1);
    check("sgn_G", g0, 1); check("sgn_max", mx0, 4);
    check("sgn_min", mn0, 14); check("sgn_abs", ad0, 6);
    compare_op(7, 8, 1'b1);
    check("sgn_ext_G", g0, 1); check("sgn_ext_abs", ad0, 15);
    check("model_pin_abs", exp_abs, 15);

    compare_op(3, 9, 1'b0);
    check("gap_pulse_valid", ov0, 1);
    in_valid = 1'b0; a = 4'd15; b = 4'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      $display("gap cycle %0d out_valid=%0d L=%0d", i, ov0, l0);
      check("gap_out_valid", ov0, 0); check("gap_hold_L", l0, 1);
      check("gap_hold_max", mx0, 9);  check("gap_cnt_l", cl0, 2);
    end

    cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) compare_op(5, 5, 1'b0);
    check("sat_cnt_e", ce1, 3); check("nosat_cnt_e", ce0, 5);
    cnt_clr = 1'b1;
    compare_op(6, 6, 1'b0);
    cnt_clr = 1'b0;
    check("clr_cnt_e", ce1, 0); check("clr_cnt_e_big", ce0, 0);
    check("clr_E", e1, 1); check("clr_max", mx1, 6); check("clr_out_valid", ov1, 1);

    compare_op(2, 9, 1'b0);
    a = 4'd9; b = 4'd2; in_valid = 1'b1; rstn = 1'b0;
    cycle();
    rstn = 1'b1; in_valid = 1'b0;
    check("midrst_L", l0, 0); check("midrst_G", g0, 0);
    check("midrst_out_valid", ov0, 0); check("midrst_cnt_l", cl0, 0);
    check("midrst_cnt_g", cg0, 0);
    $display("mid-stream reset done");

    for (int n = 0; n < 2000; n++) begin
      a           = TW'($urandom_range(0, 15));
      b           = TW'($urandom_range(0, 15));
      signed_mode = $urandom_range(0, 1) == 1;
      in_valid    = $urandom_range(0, 9) < 7;
      cnt_clr     = $urandom_range(0, 29) == 0;
      rstn        = $urandom_range(0, 99) != 0;
      cycle();
      if (n % 100 == 0)
        $display("rand %0d a=%0d b=%0d G=%0d L=%0d E=%0d cnt=%0d/%0d/%0d",
                 n, a, b, g0, l0, e0, cg0, cl0, ce0);
    end

    rstn = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparador_4b_reg.md
Name: comparador_4b_reg

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 4 bits).
- Produces one-hot greater/less/equal flags, plus max, min and absolute difference.
- Keeps saturating per-outcome event counters.
- Sits in the datapath as a single-cycle-latency, valid-qualified compare stage, driven by the system clock.

Parameters:
- WIDTH, 4, operand width in bits (minimum 2).
- CNT_W, 8, width of each outcome event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with in_valid.
- cnt_clr  input  1  synchronous clear of all event counters.
- G  output  1  registered: A > B.
- L  output  1  registered: A < B.
- E  output  1  registered: A == B.
- out_valid  output  1  registered: result outputs hold a new result.
- max_out  output  WIDTH  larger operand, per selected mode.
- min_out  output  WIDTH  smaller operand, per selected mode.
- abs_diff  output  WIDTH  |A − B| as an unsigned magnitude.
- cnt_g  output  CNT_W  number of accepted compares with A > B.
- cnt_l  output  CNT_W  number of accepted compares with A < B.
- cnt_e  output  CNT_W  number of accepted compares with A == B.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - G, L, E, out_valid, max_out, min_out, abs_diff and all counters go to 0.
  - Reset has priority over every other input, including mid-stream.
- Latency: operands accepted on edge N appear on G/L/E/max/min/abs_diff at edge N, i.e. one registered stage; out_valid=1 in the cycle after the in_valid cycle.
- in_valid=0: out_valid goes to 0; G/L/E/max/min/abs_diff hold their last values; counters unchanged.
- Flags are one-hot whenever out_valid=1 or any compare has occurred since reset. Exactly one of G, L, E is 1 after the first accepted compare.
- Unsigned mode: operands compared as 0..2^WIDTH−1.
- Signed mode: operands compared as −2^(WIDTH−1)..2^(WIDTH−1)−1.
- E is mode-independent: bitwise equality.
- max_out/min_out take the raw operand bits of the winner/loser. On equality both equal a.
- abs_diff = max − min, computed in WIDTH+1 bits and truncated to WIDTH.
  - Signed extremes: e.g. 7 − (−8) = 15 fits WIDTH unsigned bits.
- Counters:
  - On each accepted compare, exactly one of cnt_g/cnt_l/cnt_e increments by 1.
  - Counters saturate at 2^CNT_W−1; no wrap-around.
- cnt_clr=1:
  - All counters go to 0 on that edge.
  - If in_valid=1 in the same cycle, the clear wins and the new result does not count. Flags and out_valid still update.
- Back-to-back in_valid=1 every cycle is supported: full throughput, one result per cycle, no stall or backpressure.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check: assert rstn=0 for 2 cycles with arbitrary inputs -> all outputs 0. Release rstn -> still 0 until the first in_valid.
- Unsigned sequence: signed_mode=0, a=4, b=4 -> next cycle E=1, G=0, L=0, max=min=4, abs_diff=0.
  - Then b=1 -> G=1, max=4, min=1, abs_diff=3.
  - Then b=14 -> L=1, max=14, min=4, abs_diff=10.
  - Counters after the sequence: cnt_e=1, cnt_g=1, cnt_l=1.
- Signed mode: a=4 (4), b=14 (−2) -> G=1, max=4, min=14, abs_diff=6.
- Signed extremes: a=7, b=8 (−8) -> G=1, abs_diff=15.
- Gap and hold: in_valid pulse, then in_valid=0 for 3 cycles -> out_valid=1 for exactly one cycle, flags hold, counters unchanged.
- Saturation and clear: CNT_W=2, 5 equal compares -> cnt_e=3. Then cnt_clr asserted together with in_valid -> all counters 0, E updated, out_valid=1.
- Mid-stream reset: rstn=0 while in_valid=1 -> next cycle all outputs 0, and the compare is not counted.
